pfd_lock_detect: RTL and testbench



---
 rtl/pfd_lock_detect_if.sv | 33 +++
 rtl/pfd_lock_detect.sv | 205 ++++++++++++++++++++
 tb/tb_pfd_lock_detect.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pfd_lock_detect_if.sv
// Signal bundle between the phase/frequency detector and its surroundings.
// Handshake semantics: there is no ready. err_valid and slip are single-cycle
// strobes that the consumer must accept in the cycle they are high. phase_err
// holds its value between strobes. All other outputs are levels.
interface pfd_lock_detect_if #(
  parameter int ERR_W = 16
);
  logic                    ref_in;
  logic                    osc_in;
  logic                    up;
  logic                    dn;
  logic signed [ERR_W-1:0] phase_err;
  logic                    err_valid;
  logic                    slip;
  logic                    lock_n;
  logic                    ref_ok;
  logic                    osc_ok;
  logic                    ref_div_mon;
  logic                    osc_div_mon;
  logic [1:0]              state;

  modport master (
    output ref_in, osc_in,
    input  up, dn, phase_err, err_valid, slip, lock_n,
    input  ref_ok, osc_ok, ref_div_mon, osc_div_mon, state
  );

  modport slave (
    input  ref_in, osc_in,
    output up, dn, phase_err, err_valid, slip, lock_n,
    output ref_ok, osc_ok, ref_div_mon, osc_div_mon, state
  );
endinterface

// File: rtl/pfd_lock_detect.sv
// Single-clock phase/frequency detector. Both inputs are oversampled in clk,
// divided down, then compared by a three-state PFD. The block measures the
// signed distance between divided ticks, qualifies lock and watches
// input activity. The FSM state is exported on bus.state for observation.
module pfd_lock_detect #(
  parameter int REF_DIV  = 10000,
  parameter int OSC_DIV  = 12288,
  parameter int DIV_W    = 16,
  parameter int ERR_W    = 16,
  parameter int LOCK_TOL = 8,
  parameter int LOCK_CNT = 16,
  parameter int TIMEOUT  = 1000000,
  parameter int ACT_WIN  = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pfd_lock_detect_if.slave     bus
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int ACT_W  = $clog2(ACT_WIN + 1);

  localparam logic [DIV_W-1:0]  REF_LAST = DIV_W'(REF_DIV - 1);
  localparam logic [DIV_W-1:0]  OSC_LAST = DIV_W'(OSC_DIV - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX  = {1'b0, {(ERR_W-1){1'b1}}};
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [ACT_W-1:0]  ACT_MAX  = ACT_W'(ACT_WIN);
  localparam logic [31:0]       TOL      = LOCK_TOL;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DN   = 2'd2;

  logic ref_s1, ref_s2, ref_prev;
  logic osc_s1, osc_s2, osc_prev;
  logic ref_edge, osc_edge;
  logic [DIV_W-1:0] ref_cnt, osc_cnt;
  logic ref_tick, osc_tick;
  logic ref_mon, osc_mon;
  logic [1:0] state;
  logic [ERR_W-1:0] err_cnt, err_inc, phase_err_r, err_abs;
  logic err_valid_r, slip_r;
  logic [GOOD_W-1:0] good, good_next;
  logic [TO_W-1:0] to_cnt;
  logic timeout, in_tol, lock_n_r;
  logic [ACT_W-1:0] ref_act, osc_act;

  assign ref_edge = ref_s2 & ~ref_prev;
  assign osc_edge = osc_s2 & ~osc_prev;

  // Two-flop synchronisers plus the previous-value register for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {ref_s1, ref_s2, ref_prev} <= 3'b000;
      {osc_s1, osc_s2, osc_prev} <= 3'b000;
    end else begin
      ref_s1 <= bus.ref_in;  ref_s2 <= ref_s1;  ref_prev <= ref_s2;
      osc_s1 <= bus.osc_in;  osc_s2 <= osc_s1;  osc_prev <= osc_s2;
    end
  end

  // Edge dividers: a registered tick on the edge that wraps the counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt  <= '0;
      osc_cnt  <= '0;
      ref_tick <= 1'b0;
      osc_tick <= 1'b0;
      ref_mon  <= 1'b0;
      osc_mon  <= 1'b0;
    end else begin
      ref_tick <= ref_edge && (ref_cnt == REF_LAST);
      osc_tick <= osc_edge && (osc_cnt == OSC_LAST);
      if (ref_edge) ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + DIV_W'(1);
      if (osc_edge) osc_cnt <= (osc_cnt == OSC_LAST) ? '0 : osc_cnt + DIV_W'(1);
      if (ref_tick) ref_mon <= ~ref_mon;
      if (osc_tick) osc_mon <= ~osc_mon;
    end
  end

  assign err_inc = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_W'(1);

  // PFD state machine with saturating error counter. A restart inside UP/DN
  // loads 1 so the new measurement counts exactly like a fresh entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      err_cnt     <= '0;
      phase_err_r <= '0;
      err_valid_r <= 1'b0;
      slip_r      <= 1'b0;
    end else begin
      err_valid_r <= 1'b0;
      slip_r      <= 1'b0;
      case (state)
        S_IDLE: begin
          err_cnt <= '0;
          if (ref_tick && osc_tick) begin
            phase_err_r <= '0;
            err_valid_r <= 1'b1;
          end else if (ref_tick) begin
            state   <= S_UP;
            err_cnt <= ERR_W'(1);
          end else if (osc_tick) begin
            state   <= S_DN;
            err_cnt <= ERR_W'(1);
          end
        end
        S_UP: begin
          if (osc_tick) begin
            phase_err_r <= err_cnt;
            err_valid_r <= 1'b1;
            if (ref_tick) err_cnt <= ERR_W'(1);
            else begin
              state   <= S_IDLE;
              err_cnt <= '0;
            end
          end else if (ref_tick) begin
            slip_r  <= 1'b1;
            err_cnt <= ERR_W'(1);
          end else begin
            err_cnt <= err_inc;
          end
        end
        S_DN: begin
          if (ref_tick) begin
            phase_err_r <= ERR_W'(0) - err_cnt;
            err_valid_r <= 1'b1;
            if (osc_tick) err_cnt <= ERR_W'(1);
            else begin
              state   <= S_IDLE;
              err_cnt <= '0;
            end
          end else if (osc_tick) begin
            slip_r  <= 1'b1;
            err_cnt <= ERR_W'(1);
          end else begin
            err_cnt <= err_inc;
          end
        end
        default: begin
          state   <= S_IDLE;
          err_cnt <= '0;
        end
      endcase
    end
  end

  assign err_abs = phase_err_r[ERR_W-1] ? (ERR_W'(0) - phase_err_r) : phase_err_r;
  assign in_tol  = (32'(err_abs) <= TOL);
  assign timeout = (to_cnt == TO_MAX);

  // Next good-measurement count: a slip wins, then a fresh measurement, then timeout.
  always_comb begin
    good_next = good;
    if (slip_r)
      good_next = '0;
    else if (err_valid_r)
      good_next = !in_tol ? '0 : ((good == GOOD_MAX) ? good : good + GOOD_W'(1));
    else if (timeout)
      good_next = '0;
  end

  // Lock qualification and the no-measurement timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      good     <= '0;
      lock_n_r <= 1'b1;
      to_cnt   <= '0;
    end else begin
      good     <= good_next;
      lock_n_r <= (good_next != GOOD_MAX);
      if (err_valid_r)     to_cnt <= '0;
      else if (!timeout)   to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Activity windows reload on every synchronised rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_act <= '0;
      osc_act <= '0;
    end else begin
      if (ref_edge)           ref_act <= ACT_MAX;
      else if (ref_act != '0) ref_act <= ref_act - ACT_W'(1);
      if (osc_edge)           osc_act <= ACT_MAX;
      else if (osc_act != '0) osc_act <= osc_act - ACT_W'(1);
    end
  end

  assign bus.up          = (state == S_UP);
  assign bus.dn          = (state == S_DN);
  assign bus.phase_err   = phase_err_r;
  assign bus.err_valid   = err_valid_r;
  assign bus.slip        = slip_r;
  assign bus.lock_n      = lock_n_r;
  assign bus.ref_ok      = (ref_act != '0);
  assign bus.osc_ok      = (osc_act != '0);
  assign bus.ref_div_mon = ref_mon;
  assign bus.osc_div_mon = osc_mon;
  assign bus.state       = state;

endmodule

// File: tb/tb_pfd_lock_detect.sv
// Directed bench for pfd_lock_detect. Two instances share the input waveforms:
// one with a 16-bit error and one with a 4-bit error to exercise saturation.
// Expected measurements come from the tick times of the driven waveforms.
module tb_pfd_lock_detect;
  localparam int DIV      = 4;
  localparam int LOCK_TOL = 8;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 200;
  localparam int ACT_WIN  = 64;
  localparam int PER      = 8;
  localparam int SAT4     = 7;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pfd_lock_detect_if #(.ERR_W(16)) bus_a ();
  pfd_lock_detect_if #(.ERR_W(4))  bus_b ();

  pfd_lock_detect #(.REF_DIV(DIV), .OSC_DIV(DIV), .DIV_W(16), .ERR_W(16),
    .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .ACT_WIN(ACT_WIN))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));

  pfd_lock_detect #(.REF_DIV(DIV), .OSC_DIV(DIV), .DIV_W(16), .ERR_W(4),
    .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .ACT_WIN(ACT_WIN))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp4_q[$];
  int ref_t_q[$];
  int osc_t_q[$];
  int ref_edges, osc_edges;
  bit ref_en, osc_en;
  int ref_ofs, osc_ofs, wave_t;
  int good_m;
  bit lock_chk;
  logic lock_exp;
  int up_run, last_up_run, dn_run, last_dn_run;
  int slip_cnt;
  logic slip_prev;
  int last_ev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Waveform driver plus tick-time model; pushes expectations as ticks pair up.
  task automatic drive_inputs();
    logic ref_new, osc_new;
    int d;
    wave_t++;
    ref_new = ref_en && (wave_t >= ref_ofs) && (((wave_t - ref_ofs) % PER) < PER/2);
    osc_new = osc_en && (wave_t >= osc_ofs) && (((wave_t - osc_ofs) % PER) < PER/2);
    if (ref_new && !bus_a.ref_in) begin
      ref_edges++;
      if (ref_edges == DIV) begin ref_edges = 0; ref_t_q.push_back(cyc); end
    end
    if (osc_new && !bus_a.osc_in) begin
      osc_edges++;
      if (osc_edges == DIV) begin osc_edges = 0; osc_t_q.push_back(cyc); end
    end
    bus_a.ref_in = ref_new;  bus_b.ref_in = ref_new;
    bus_a.osc_in = osc_new;  bus_b.osc_in = osc_new;
    while (ref_t_q.size() > 0 && osc_t_q.size() > 0) begin
      d = osc_t_q.pop_front() - ref_t_q.pop_front();
      exp_q.push_back(32'(d));
      exp4_q.push_back(32'((d > SAT4) ? SAT4 : ((d < -SAT4) ? -SAT4 : d)));
    end
  endtask

  // One clock: sample outputs #1 after the edge, score them, then drive inputs.
  task automatic step();
    logic [31:0] e;
    int ei;
    @(posedge clk);
    #1;
    cyc++;
    if (lock_chk) begin
      check("lock_n_after_meas", 32'(bus_a.lock_n), 32'(lock_exp));
      lock_chk = 0;
    end
    if (bus_a.err_valid === 1'b1) begin
      last_ev = cyc;
      if (exp_q.size() == 0) check("unexpected_err_valid_a", 32'(1), 32'(0));
      else begin
        e = exp_q.pop_front();
        check("phase_err_a", 32'($signed(bus_a.phase_err)), e);
        ei = $signed(e);
        if (ei < 0) ei = -ei;
        good_m = (ei <= LOCK_TOL) ? ((good_m < LOCK_CNT) ? good_m + 1 : good_m) : 0;
        lock_chk = 1;
        lock_exp = (good_m != LOCK_CNT);
      end
    end
    if (bus_b.err_valid === 1'b1) begin
      if (exp4_q.size() == 0) check("unexpected_err_valid_b", 32'(1), 32'(0));
      else check("phase_err_b", 32'($signed(bus_b.phase_err)), exp4_q.pop_front());
    end
    if (bus_a.up === 1'b1) up_run++;
    else if (up_run > 0) begin last_up_run = up_run; up_run = 0; end
    if (bus_a.dn === 1'b1) dn_run++;
    else if (dn_run > 0) begin last_dn_run = dn_run; dn_run = 0; end
    if (bus_a.slip === 1'b1) begin
      slip_cnt++;
      check("slip_one_cycle", 32'(slip_prev), 32'(0));
    end
    slip_prev = bus_a.slip;
    drive_inputs();
  endtask

  task automatic check_reset_values();
    check("rst_up", 32'(bus_a.up), 32'(0));
    check("rst_dn", 32'(bus_a.dn), 32'(0));
    check("rst_phase_err", 32'($signed(bus_a.phase_err)), 32'(0));
    check("rst_err_valid", 32'(bus_a.err_valid), 32'(0));
    check("rst_slip", 32'(bus_a.slip), 32'(0));
    check("rst_lock_n", 32'(bus_a.lock_n), 32'(1));
    check("rst_ref_ok", 32'(bus_a.ref_ok), 32'(0));
    check("rst_osc_ok", 32'(bus_a.osc_ok), 32'(0));
    check("rst_ref_div_mon", 32'(bus_a.ref_div_mon), 32'(0));
    check("rst_osc_div_mon", 32'(bus_a.osc_div_mon), 32'(0));
    check("rst_state", 32'(bus_a.state), 32'(0));
    check("rst_up_b", 32'(bus_b.up), 32'(0));
    check("rst_err_valid_b", 32'(bus_b.err_valid), 32'(0));
  endtask

  task automatic clear_model();
    exp_q.delete();  exp4_q.delete();
    ref_t_q.delete(); osc_t_q.delete();
    ref_edges = 0; osc_edges = 0; good_m = 0; lock_chk = 0;
    up_run = 0; last_up_run = 0; dn_run = 0; last_dn_run = 0;
    slip_cnt = 0; slip_prev = 1'b0;
  endtask

  // Asynchronous reset pulse between clock edges, released mid-cycle.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    ref_en = 0; osc_en = 0;
    clear_model();
    repeat (4) step();
    #2;
    reset_n = 1'b1;
    step();
  endtask

  task automatic start_wave(input int r_ofs, input int o_ofs);
    ref_ofs = r_ofs; osc_ofs = o_ofs; wave_t = -1;
    ref_en = 1; osc_en = 1;
  endtask

  task automatic drain();
    ref_en = 0; osc_en = 0;
    repeat (10) step();
    check("drain_a", 32'(exp_q.size()), 32'(0));
    check("drain_b", 32'(exp4_q.size()), 32'(0));
  endtask

  initial begin
    bit seen;
    bus_a.ref_in = 1'b0; bus_a.osc_in = 1'b0;
    bus_b.ref_in = 1'b0; bus_b.osc_in = 1'b0;
    ref_en = 0; osc_en = 0; wave_t = -1; ref_ofs = 0; osc_ofs = 0; last_ev = 0;
    clear_model();
    step(); step();
    check_reset_values();
    #2;
    reset_n = 1'b1;
    step();

    // In phase: zero error every divided period, lock after LOCK_CNT.
    start_wave(0, 0);
    repeat (6 * DIV * PER + 8) step();
    check("t1_lock_n", 32'(bus_a.lock_n), 32'(0));
    check("t1_ref_ok", 32'(bus_a.ref_ok), 32'(1));
    check("t1_osc_ok", 32'(bus_a.osc_ok), 32'(1));
    check("t1_no_up", 32'(last_up_run), 32'(0));
    drain();

    // Both inputs stop while locked: activity drops, then lock times out.
    for (int i = 0; i < 400 && cyc < last_ev + TIMEOUT - 20; i++) step();
    check("t4a_lock_held", 32'(bus_a.lock_n), 32'(0));
    check("t4a_ref_ok", 32'(bus_a.ref_ok), 32'(0));
    check("t4a_osc_ok", 32'(bus_a.osc_ok), 32'(0));
    for (int i = 0; i < 400 && cyc < last_ev + TIMEOUT + 10; i++) step();
    check("t4a_lock_timeout", 32'(bus_a.lock_n), 32'(1));
    do_reset();

    // osc lags by 10 clk: up pulses of 10, +10 errors, never locks.
    start_wave(0, 10);
    repeat (7 * DIV * PER) step();
    check("t2_lock_n", 32'(bus_a.lock_n), 32'(1));
    check("t2_up_run", 32'(last_up_run), 32'(10));
    check("t2_no_dn", 32'(last_dn_run), 32'(0));
    drain();
    do_reset();

    // osc leads by 5 clk: dn pulses of 5, -5 errors, locks.
    start_wave(5, 0);
    repeat (7 * DIV * PER) step();
    check("t3_lock_n", 32'(bus_a.lock_n), 32'(0));
    check("t3_dn_run", 32'(last_dn_run), 32'(5));
    check("t3_no_up", 32'(last_up_run), 32'(0));

    // Locked, then osc stops: a second ref tick in UP is a slip.
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (bus_a.err_valid === 1'b1) seen = 1;
    end
    check("t4b_wait_err_valid", 32'(seen), 32'(1));
    osc_en = 0;
    slip_cnt = 0;
    repeat (80) step();
    check("t4b_slip_count", 32'(slip_cnt), 32'(1));
    check("t4b_lock_n", 32'(bus_a.lock_n), 32'(1));
    check("t4b_osc_ok", 32'(bus_a.osc_ok), 32'(0));
    check("t4b_ref_ok", 32'(bus_a.ref_ok), 32'(1));
    check("t4b_in_up", 32'(bus_a.state), 32'(1));
    check("t4b_queue", 32'(exp_q.size()), 32'(0));
    do_reset();

    // Reset while UP aborts the measurement; a fresh one follows.
    start_wave(0, 10);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (bus_a.up === 1'b1) seen = 1;
    end
    check("t5_wait_up", 32'(seen), 32'(1));
    do_reset();
    start_wave(0, 10);
    repeat (3 * DIV * PER + 8) step();
    check("t5_up_run", 32'(last_up_run), 32'(10));
    drain();
    do_reset();

    // osc lags by 20 clk: 16-bit instance reports 20, 4-bit saturates at +7.
    start_wave(0, 20);
    repeat (4 * DIV * PER + 8) step();
    check("t6_up_run", 32'(last_up_run), 32'(20));
    check("t6_err_b", 32'($signed(bus_b.phase_err)), 32'(SAT4));
    check("t6_err_a", 32'($signed(bus_a.phase_err)), 32'(20));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
